mult_div_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers, sitting in the EX stage beside the ALU of the 5-stage MIPS pipeline.
- Consumes forwarded EX operands (SrcAE / write-data path) and the decoded MD opcode from the ID/EX control register.
- Produces HI/LO for mfhi/mflo through the EX result mux, plus a busy flag the hazard unit uses to stall D.
- Models fixed multi-cycle latency; the arithmetic itself is computed in one step and committed when the count expires.

---
 rtl/mult_div_unit_pkg.sv | 17 +
 rtl/mult_div_unit.sv | 113 +++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared MD opcode encodings and default iteration lengths, used by the
// multiply/divide unit, the control decoder and the stall unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } mdOp_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// Purpose: EX-stage multiply/divide unit owning the HI/LO registers.
// Latency: MULT/MULTU busy MULT_CYCLES, DIV/DIVU busy DIV_CYCLES; MTHI/MTLO single cycle.
// Backpressure: none; start while busy is dropped, the hazard unit stalls D on start|busy.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       opReg;
    logic [31:0]      opA;
    logic [31:0]      opB;

    logic [63:0] prodS;
    logic [63:0] prodU;
    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] divisor;
    logic [31:0] quoMag;
    logic [31:0] remMag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] resHi;
    logic [31:0] resLo;

    assign prodU = {32'd0, opA} * {32'd0, opB};
    assign prodS = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};

    // Signed divide via magnitudes: truncation toward zero falls out naturally,
    // and 0x80000000 / -1 yields 0x80000000 remainder 0 without a special case.
    assign negA    = (opReg == MD_DIV) && opA[31];
    assign negB    = (opReg == MD_DIV) && opB[31];
    assign magA    = negA ? -opA : opA;
    assign magB    = negB ? -opB : opB;
    assign divisor = (magB == 32'd0) ? 32'd1 : magB;
    assign quoMag  = magA / divisor;
    assign remMag  = magA % divisor;
    assign quo     = (negA ^ negB) ? -quoMag : quoMag;
    assign rem     = negA ? -remMag : remMag;

    always_comb begin
        resHi = hi;
        resLo = lo;
        case (opReg)
            MD_MULT:  {resHi, resLo} = prodS;
            MD_MULTU: {resHi, resLo} = prodU;
            MD_DIV, MD_DIVU: begin
                if (opB != 32'd0) begin
                    resHi = rem;
                    resLo = quo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt   <= '0;
            busy  <= 1'b0;
            opReg <= '0;
            opA   <= '0;
            opB   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                hi   <= resHi;
                lo   <= resLo;
                busy <= 1'b0;
            end
        end else if (start) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    opA   <= a;
                    opB   <= b;
                    opReg <= md_op;
                    cnt   <= CNT_W'(MULT_CYCLES);
                    busy  <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    opA   <= a;
                    opB   <= b;
                    opReg <= md_op;
                    cnt   <= CNT_W'(DIV_CYCLES);
                    busy  <= 1'b1;
                end
                MD_MTHI: hi <= a;
                MD_MTLO: lo <= a;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of arithmetic vectors plus
// hand-written sequences for MTHI/MTLO, divide-by-zero, ignored starts and async reset.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        clr;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests  = 0;
    int failed = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          cycles;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one start pulse; returns at #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        md_op = op;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until busy drops, bounded so a stuck busy cannot hang the run.
    task automatic waitIdle(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int total;

        clr   = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        a     = 32'd0;
        b     = 32'd0;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{MD_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
        vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{MD_MULT,  32'd6,        32'd7,        32'h00000000, 32'd42,       5};
        vecs[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[8] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[9] = '{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        clr = 1'b1;
        @(posedge clk);
        #1;

        // Each vector issues in the first cycle the previous one shows busy=0,
        // and scrambles a/b during RUN to prove the operands were latched.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].va, vecs[i].vb);
            a = $urandom;
            b = $urandom;
            waitIdle(n);
            check($sformatf("vec%0d_cycles", i), n, vecs[i].cycles);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].expHi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].expLo);
        end

        issue(MD_MTHI, 32'h11, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(MD_MTLO, 32'h22, 32'd0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h11);
        check("mtlo_lo", lo, 32'h22);

        // Divide by zero with an MTHI attempted mid-run: both must leave HI/LO alone.
        issue(MD_DIV, 32'd5, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("run_hold_hi", hi, 32'h11);
        issue(MD_MTHI, 32'h99, 32'd0);
        waitIdle(n);
        total = 4 + n;
        check("divzero_cycles", total, 10);
        check("divzero_hi", hi, 32'h11);
        check("divzero_lo", lo, 32'h22);

        issue(3'd6, 32'hDEAD, 32'hBEEF);
        check("undef_busy", {31'd0, busy}, 32'd0);
        check("undef_hi", hi, 32'h11);
        check("undef_lo", lo, 32'h22);

        // Async reset mid-divide, asserted between clock edges.
        issue(MD_DIV, 32'd100, 32'd3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #3;
        clr = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        #2;
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("post_arst_busy", {31'd0, busy}, 32'd0);
        check("post_arst_lo", lo, 32'd0);

        issue(MD_MULT, 32'd6, 32'd7);
        waitIdle(n);
        check("post_arst_mult_cycles", n, 5);
        check("post_arst_mult_hi", hi, 32'd0);
        check("post_arst_mult_lo", lo, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
